// File: rtl/anode_scan_driver_if.sv
// Digit shift-in handshake between an upstream source
// and the anode scan driver.
interface anode_scan_driver_if;
   logic [3:0] digit_in;
   logic       digit_valid;
   logic       digit_ready;

   modport master (
      output digit_in,
      output digit_valid,
      input  digit_ready
   );

   modport slave (
      input  digit_in,
      input  digit_valid,
      output digit_ready
   );
endinterface

// File: rtl/anode_scan_driver.sv
// Four-digit multiplexed display scanner with blanking
// between digits and a BLANK-only digit shift-in port.
module anode_scan_driver #(
   parameter logic [15:0] REFRESH_DIV  = 16'd12500,
   parameter logic [15:0] BLANK_CYCLES = 16'd50
) (
   input  logic                clk,
   input  logic                reset,
   anode_scan_driver_if.slave  bus,
   output logic [3:0]          digit1,
   output logic [3:0]          digit2,
   output logic [3:0]          digit3,
   output logic [3:0]          digit4,
   output logic [3:0]          anode2,
   output logic [3:0]          anode
);

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  an2_q, an2_d;
   logic [3:0]  an_q, an_d;
   logic [15:0] dig_q, dig_d;
   logic        last;
   logic        xfer;

   function automatic logic [3:0] rotate(input logic [3:0] s);
      logic [3:0] r;
      case (s)
         4'b0111: r = 4'b1011;
         4'b1011: r = 4'b1101;
         4'b1101: r = 4'b1110;
         4'b1110: r = 4'b0111;
         default: r = 4'b0111;
      endcase
      return r;
   endfunction

   assign bus.digit_ready = (state_q == BLANK);
   assign xfer = bus.digit_valid && (state_q == BLANK);

   // Next state, phase counter, selects and digit shift.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      an2_d   = an2_q;
      dig_d   = dig_q;
      last    = 1'b0;
      if (state_q == BLANK)
         last = (cnt_q == BLANK_CYCLES - 16'd1);
      else
         last = (cnt_q == REFRESH_DIV - 16'd1);
      if (last) begin
         cnt_d = 16'd0;
         if (state_q == BLANK) begin
            state_d = ON;
         end else begin
            state_d = BLANK;
            an2_d   = rotate(an2_q);
         end
      end
      if (xfer)
         dig_d = {dig_q[11:0], bus.digit_in};
      // Anode is registered from the next-state view so it
      // tracks anode2 in ON without a combinational path.
      an_d = (state_d == ON) ? an2_d : 4'b1111;
   end

   // State and datapath registers with async active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= BLANK;
         cnt_q   <= 16'd0;
         an2_q   <= 4'b0111;
         an_q    <= 4'b1111;
         dig_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         an2_q   <= an2_d;
         an_q    <= an_d;
         dig_q   <= dig_d;
      end
   end

   assign anode2 = an2_q;
   assign anode  = an_q;
   assign digit1 = dig_q[3:0];
   assign digit2 = dig_q[7:4];
   assign digit3 = dig_q[11:8];
   assign digit4 = dig_q[15:12];

endmodule

// File: tb/tb_anode_scan_driver.sv
// Scoreboard bench for anode_scan_driver: 4/2 timing
// instance with shift-in traffic plus a 1/1 instance.
module tb_anode_scan_driver;

   localparam int R  = 4;
   localparam int B  = 2;
   localparam int R1 = 1;
   localparam int B1 = 1;

   logic clk;
   logic reset;
   logic [3:0] d1, d2, d3, d4, an2, an;
   logic [3:0] e1, e2, e3, e4, f2, f1;

   anode_scan_driver_if bus ();
   anode_scan_driver_if bus1 ();

   anode_scan_driver #(
      .REFRESH_DIV (16'd4),
      .BLANK_CYCLES(16'd2)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .digit1(d1),
      .digit2(d2),
      .digit3(d3),
      .digit4(d4),
      .anode2(an2),
      .anode (an)
   );

   anode_scan_driver #(
      .REFRESH_DIV (16'd1),
      .BLANK_CYCLES(16'd1)
   ) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1),
      .digit1(e1),
      .digit2(e2),
      .digit3(e3),
      .digit4(e4),
      .anode2(f2),
      .anode (f1)
   );

   typedef struct {
      logic [3:0]  an;
      logic [3:0]  an2;
      logic        rdy;
      logic [15:0] dg;
      logic [3:0]  an1;
      logic [3:0]  an21;
   } exp_t;

   exp_t        sb[$];
   logic [3:0]  src[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          t;
   logic [15:0] digs;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [15:0] got,
                        input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d: got %h expected %h",
                  tag, t, got, exp);
      end
   endtask

   function automatic logic [3:0] sel(int tt, int b, int r);
      int k;
      k = (tt / (b + r)) % 4;
      return ~(4'b1000 >> k);
   endfunction

   function automatic logic blank_at(int tt, int b, int r);
      return (tt % (b + r)) < b;
   endfunction

   function automatic exp_t model(int tt, logic [15:0] dg);
      exp_t e;
      e.an2  = sel(tt, B, R);
      e.an   = blank_at(tt, B, R) ? 4'hF : e.an2;
      e.rdy  = blank_at(tt, B, R);
      e.dg   = dg;
      e.an21 = sel(tt, B1, R1);
      e.an1  = blank_at(tt, B1, R1) ? 4'hF : e.an21;
      return e;
   endfunction

   task automatic compare();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 16'd1, 16'd0);
         return;
      end
      e = sb.pop_front();
      check("anode", {12'd0, an}, {12'd0, e.an});
      check("anode2", {12'd0, an2}, {12'd0, e.an2});
      check("ready", {15'd0, bus.digit_ready}, {15'd0, e.rdy});
      check("digits", {d4, d3, d2, d1}, e.dg);
      check("anode_1x1", {12'd0, f1}, {12'd0, e.an1});
      check("anode2_1x1", {12'd0, f2}, {12'd0, e.an21});
   endtask

   // One cycle per iteration, entered at a falling edge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         compare();
         bus.digit_valid = (src.size() > 0);
         bus.digit_in    = (src.size() > 0) ? src[0] : 4'd0;
         if (src.size() > 0 && blank_at(t, B, R)) begin
            digs = {digs[11:0], src[0]};
            void'(src.pop_front());
         end
         t++;
         sb.push_back(model(t, digs));
         @(negedge clk);
      end
   endtask

   task automatic reset_checks();
      check("rst_anode", {12'd0, an}, 16'h000F);
      check("rst_anode2", {12'd0, an2}, 16'h0007);
      check("rst_digits", {d4, d3, d2, d1}, 16'h0000);
      check("rst_ready", {15'd0, bus.digit_ready}, 16'd1);
      check("rst_anode_1x1", {12'd0, f1}, 16'h000F);
   endtask

   initial begin
      bus.digit_in     = 4'd0;
      bus.digit_valid  = 1'b0;
      bus1.digit_in    = 4'd0;
      bus1.digit_valid = 1'b0;
      reset = 1'b0;
      t     = 0;
      digs  = 16'd0;

      // Valid offered during reset must not shift anything.
      bus.digit_valid = 1'b1;
      bus.digit_in    = 4'd9;
      repeat (3) @(negedge clk);
      reset_checks();
      bus.digit_valid = 1'b0;
      reset = 1'b1;
      sb.push_back(model(0, digs));

      // Held valid: 1,2 taken in first BLANK, 3 waits for next.
      src = '{4'd1, 4'd2, 4'd3, 4'd4};
      run(26);

      // Preload 9,8,7,6 then 5, plus out-of-range BCD.
      src = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd10, 4'd15};
      run(30);

      // Walk to the first ON cycle of a digit, then reset.
      while (!(t % (B + R) == B)) run(1);
      #1;
      compare();
      #1;
      reset = 1'b0;
      #1;
      reset_checks();
      sb.delete();
      src.delete();
      bus.digit_valid = 1'b1;
      bus.digit_in    = 4'd3;
      @(negedge clk);
      @(negedge clk);
      reset_checks();
      bus.digit_valid = 1'b0;
      t    = 0;
      digs = 16'd0;
      reset = 1'b1;
      sb.push_back(model(0, digs));

      // Random traffic after reset recovery.
      for (int i = 0; i < 12; i++)
         src.push_back(4'($urandom_range(0, 15)));
      run(50);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/anode_scan_driver.md
ANODE_SCAN_DRIVER -- requirements
Module: anode_scan_driver

Interface
REQ-001 Parameter: REFRESH_DIV, default 16'd12500, ON-phase length per digit in clk cycles (legal 1..65535).
REQ-002 Parameter: BLANK_CYCLES, default 16'd50, blanking length between digits in clk cycles (legal 1..65535).
REQ-003 Port: clk  input  1  single system clock, all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: digit_in  input  4  BCD value offered for shift-in.
REQ-006 Port: digit_valid  input  1  digit_in is valid this cycle.
REQ-007 Port: digit_ready  output  1  block accepts digit_in this cycle.
REQ-008 Port: digit1..digit4  output  4 each  stored digits; digit1 rightmost, digit4 leftmost; feed the BCD digit-select stage.
REQ-009 Port: anode2  output  4  active-low one-hot select for the digit-select stage, leads anode.
REQ-010 Port: anode  output  4  active-low one-hot drive to the display, 4'b1111 = all off.

Function
REQ-011 FSM states SHALL be BLANK and ON, with a 16-bit phase counter cleared on every state change.
REQ-012 In BLANK, anode SHALL be 4'b1111 while anode2 already holds the next digit select, so downstream mux/decoder settle before light-up.
REQ-013 BLANK SHALL last exactly BLANK_CYCLES cycles, then transition to ON.
REQ-014 In ON, anode SHALL equal anode2 (registered, no combinational path from state to anode glitches).
REQ-015 ON SHALL last exactly REFRESH_DIV cycles, then transition to BLANK.
REQ-016 On the ON->BLANK transition anode2 SHALL rotate 0111 -> 1011 -> 1101 -> 1110 -> 0111.
REQ-017 Any anode2 value outside those four SHALL rotate to 4'b0111 on the next ON->BLANK transition.
REQ-018 digit_ready SHALL be 1 exactly when state is BLANK, 0 in ON (digits never change while lit).
REQ-019 Transfer occurs when digit_valid and digit_ready are both 1 at a rising edge.
REQ-020 On transfer: digit4<=digit3, digit3<=digit2, digit2<=digit1, digit1<=digit_in; old digit4 discarded.
REQ-021 Transfer on the last BLANK cycle SHALL be accepted; new digits visible from the following ON cycle.
REQ-022 digit_valid while digit_ready=0 SHALL be ignored; no buffering, upstream holds valid.
REQ-023 Back-to-back transfers SHALL be accepted every cycle of BLANK (one shift per cycle).
REQ-024 digit_in values 10..15 SHALL be stored unmodified.
REQ-025 Per-digit period SHALL be BLANK_CYCLES+REFRESH_DIV cycles; full frame 4x that.

Reset
REQ-026 On reset low, asynchronously: state=BLANK, counter=0, anode=4'b1111, anode2=4'b0111, digit1..digit4=0.
REQ-027 During reset, digit_ready SHALL be 1 (state BLANK) but no transfer SHALL occur.
REQ-028 After reset release, first cycle SHALL be BLANK cycle 0 of digit1 (anode2=0111).
REQ-029 Reset asserted mid-ON or mid-BLANK SHALL immediately force REQ-026 values; no partial shift retained.

Verification (REFRESH_DIV=4, BLANK_CYCLES=2 unless stated)
REQ-030 Release reset, no input -> anode=1111 cycles 0-1, 0111 cycles 2-5, 1111 cycles 6-7 with anode2=1011, 1011 cycles 8-11; anode2 back to 0111 at cycle 24.
REQ-031 Hold digit_valid=1 with digit_in=1,2,3,4 in first BLANK -> only 2 accepted (cycles 0,1): digit1=2, digit2=1; digit_ready=0 cycles 2-5, third value accepted at cycle 6.
REQ-032 Preload digits 9,8,7,6 (digit4..digit1) then one transfer of 5 -> digit4=8, digit3=7, digit2=6, digit1=5.
REQ-033 digit_valid=1 throughout ON -> no digit change, digit_ready=0 every ON cycle.
REQ-034 Assert reset at cycle 3 (ON, anode=0111) -> anode=1111, anode2=0111, digits=0 same cycle, before next clk edge.
REQ-035 BLANK_CYCLES=1, REFRESH_DIV=1 -> anode alternates 1111 / one-hot every cycle, rotating each pair, frame 8 cycles.
